// File: rtl/student_or_unit_if.sv
// Operand/result bundle for student_or_unit: operands and clear in, OR result and activity statistics out.
interface student_or_unit_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] act_cnt;
  logic             act_sat;

  modport master (
    output a, b, clr,
    input  out, out_q, rise, fall, act_cnt, act_sat
  );

  modport slave (
    input  a, b, clr,
    output out, out_q, rise, fall, act_cnt, act_sat
  );
endinterface

// File: rtl/student_or_unit.sv
// Bitwise OR with a registered copy, edge pulses on the reduced result and a saturating activity counter.
module student_or_unit #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  student_or_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] out_q_d, out_q_q;
  logic             rise_d, rise_q;
  logic             fall_d, fall_q;
  logic [CNT_W-1:0] act_cnt_d, act_cnt_q;

  // Combinational result: independent of clock, reset and clear.
  assign bus.out = bus.a | bus.b;

  always_comb begin
    out_q_d   = bus.out;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    act_cnt_d = act_cnt_q;

    // Edges are judged on the reduced value crossing between old and new out_q.
    rise_d = (|bus.out) & ~(|out_q_q);
    fall_d = ~(|bus.out) & (|out_q_q);

    if (bus.clr) begin
      act_cnt_d = '0;
    end else if ((|bus.out) && (act_cnt_q != CNT_MAX)) begin
      act_cnt_d = act_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_q   <= '0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      act_cnt_q <= '0;
    end else begin
      out_q_q   <= out_q_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      act_cnt_q <= act_cnt_d;
    end
  end

  assign bus.out_q   = out_q_q;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.act_cnt = act_cnt_q;
  assign bus.act_sat = (act_cnt_q == CNT_MAX);

endmodule

// File: tb/tb_student_or_unit.sv
// Scoreboard bench for student_or_unit: behavioural model queues expected registered outputs per edge.
module tb_student_or_unit;

  localparam int unsigned W    = 4;
  localparam int unsigned CW   = 3;
  localparam int          CMAX = (1 << CW) - 1;

  typedef struct {
    logic [W-1:0] out_q;
    logic         rise;
    logic         fall;
    int           cnt;
    logic         sat;
  } exp_t;

  logic clk;
  logic rst_n;

  student_or_unit_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  student_or_unit_if bus1 ();

  student_or_unit #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Default-parameter instance held in reset: its OR output must still follow the operands.
  student_or_unit u_dut1 (
    .clk   (clk),
    .rst_n (1'b0),
    .bus   (bus1)
  );

  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];

  int           m_cnt;
  logic [W-1:0] m_outq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the outputs must be after the coming edge.
  task automatic model_step(input logic [W-1:0] a, input logic [W-1:0] b, input logic clr,
                            input logic rst, output exp_t e);
    int nv;
    int ov;
    nv = int'(a | b);
    ov = int'(m_outq);
    if (!rst) begin
      m_outq = '0;
      m_cnt  = 0;
      e.rise = 1'b0;
      e.fall = 1'b0;
    end else begin
      e.rise = (nv != 0) && (ov == 0);
      e.fall = (nv == 0) && (ov != 0);
      m_outq = a | b;
      if (clr)           m_cnt = 0;
      else if (nv != 0)  m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
    end
    e.out_q = m_outq;
    e.cnt   = m_cnt;
    e.sat   = (m_cnt == CMAX);
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic clr, input logic rst);
    exp_t e;
    @(negedge clk);
    bus.a   = a;
    bus.b   = b;
    bus.clr = clr;
    rst_n   = rst;
    #1;
    check("out_comb", 32'(bus.out), 32'(a | b));
    if (!rst) begin
      check("rst_out_q",   32'(bus.out_q),   32'd0);
      check("rst_act_cnt", 32'(bus.act_cnt), 32'd0);
      check("rst_rise",    32'(bus.rise),    32'd0);
      check("rst_fall",    32'(bus.fall),    32'd0);
    end
    model_step(a, b, clr, rst, e);
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_q",   32'(bus.out_q),   32'(e.out_q));
        check("rise",    32'(bus.rise),    32'(e.rise));
        check("fall",    32'(bus.fall),    32'(e.fall));
        check("act_cnt", 32'(bus.act_cnt), 32'(e.cnt));
        check("act_sat", 32'(bus.act_sat), 32'(e.sat));
        if (bus.rise && bus.fall) check("rise_fall_excl", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rr;
    m_cnt   = 0;
    m_outq  = '0;
    rst_n   = 1'b0;
    bus.a   = '0;
    bus.b   = '0;
    bus.clr = 1'b0;
    bus1.a  = '0;
    bus1.b  = '0;
    bus1.clr = 1'b0;

    // 1-bit truth table on the instance stuck in reset.
    for (int i = 0; i < 4; i++) begin
      bus1.a = 1'(i >> 1);
      bus1.b = 1'(i);
      #1;
      check("truth_out", 32'(bus1.out), (i == 0) ? 32'd0 : 32'd1);
      check("truth_out_q_in_reset", 32'(bus1.out_q), 32'd0);
    end

    drive('0, '0, 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);

    // Single-bit activity for three edges, then idle.
    repeat (3) drive(4'b0001, 4'b0000, 1'b0, 1'b1);
    repeat (2) drive(4'b0000, 4'b0000, 1'b0, 1'b1);

    // Multi-bit OR, then hold activity into saturation.
    drive(4'b1010, 4'b0110, 1'b0, 1'b1);
    repeat (9) drive(4'b0100, 4'b0000, 1'b0, 1'b1);

    // Clear while active wins over increment.
    drive(4'b0001, 4'b0000, 1'b1, 1'b1);
    drive(4'b0001, 4'b0000, 1'b0, 1'b1);

    // Reset mid-count, then first edge after reset must rise.
    drive('0, '0, 1'b0, 1'b0);
    repeat (5) drive(4'b0011, 4'b0000, 1'b0, 1'b1);
    drive(4'b0011, 4'b0101, 1'b0, 1'b0);
    drive(4'b1000, 4'b0000, 1'b0, 1'b1);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        ra = '0;
        rb = '0;
      end else begin
        ra = W'($urandom);
        rb = W'($urandom);
      end
      rc = ($urandom_range(0, 11) == 0);
      rr = ($urandom_range(0, 63) != 0);
      drive(ra, rb, rc, rr);
    end

    repeat (2) drive('0, '0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
